// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Module  : if_fetch_ctrl_pkg
// Brief   : Shared fetch-state encoding and constants for the IF-stage fetch
//           controller and its skid buffer.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ---------------------------------------------------------------------------
// Module  : if_skid_buf
// Brief   : One-entry {pc,instr} holding register with load/drain/discard.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module if_skid_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_discard,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_instr <= c_NOP_INSTR;
    end else if (i_discard || i_drain) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : if_fetch_ctrl
// Brief   : IF-stage fetch controller: PC, imem handshake, IF/ID register,
//           stall hold and redirect kill. FETCH_STATS_EN adds stat counters.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_DEFAULT_RESET_PC,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] target_pc,
  input  logic        id_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_killed,
`endif
  output logic        redirect
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_kill, w_kill_nxt;
  logic         r_ifid_valid;
  logic [31:0]  r_ifid_pc, r_ifid_instr;

  logic         w_redirect;
  logic         w_ifid_load;
  logic [31:0]  w_ifid_pc, w_ifid_instr;
  logic         w_skid_load, w_skid_drain, w_skid_discard;
  logic         w_skid_valid;
  logic [31:0]  w_skid_pc, w_skid_instr;
  logic [31:0]  w_pc_seq;

  assign w_redirect = id_valid & (branch | jump);
  assign w_pc_seq   = r_pc + 32'(PC_STEP);

  if_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_skid_load),
    .i_drain   (w_skid_drain),
    .i_discard (w_skid_discard),
    .i_pc      (r_pc),
    .i_instr   (imem_rsp_data),
    .o_valid   (w_skid_valid),
    .o_pc      (w_skid_pc),
    .o_instr   (w_skid_instr)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_ifid_load    = 1'b0;
    w_ifid_pc      = r_pc;
    w_ifid_instr   = imem_rsp_data;
    w_skid_load    = 1'b0;
    w_skid_drain   = 1'b0;
    w_skid_discard = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt = ST_WAIT;
          w_kill_nxt  = w_redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt = ST_REQ;
          if (r_kill || w_redirect) begin
            w_kill_nxt = 1'b0;
          end else if (!id_stall) begin
            w_ifid_load = 1'b1;
            w_pc_nxt    = w_pc_seq;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_redirect) begin
          w_skid_discard = 1'b1;
          w_state_nxt    = ST_REQ;
        end else if (!id_stall && w_skid_valid) begin
          w_skid_drain = 1'b1;
          w_ifid_load  = 1'b1;
          w_ifid_pc    = w_skid_pc;
          w_ifid_instr = w_skid_instr;
          w_pc_nxt     = w_pc_seq;
          w_state_nxt  = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase
    // Redirect wins over any sequential PC advance.
    if (w_redirect) begin
      w_pc_nxt = target_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= c_NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_redirect) begin
        r_ifid_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= w_ifid_pc;
        r_ifid_instr <= w_ifid_instr;
      end else if (!id_stall) begin
        r_ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic        w_drop;
  logic [31:0] r_stat_redirects, r_stat_killed;

  assign w_drop = ((r_state == ST_WAIT) && imem_rsp_valid && (r_kill || w_redirect)) ||
                  ((r_state == ST_HOLD) && w_redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_redirects <= 32'h0;
      r_stat_killed    <= 32'h0;
    end else begin
      if (w_redirect && (r_stat_redirects != 32'hFFFF_FFFF))
        r_stat_redirects <= r_stat_redirects + 32'd1;
      if (w_drop && (r_stat_killed != 32'hFFFF_FFFF))
        r_stat_killed <= r_stat_killed + 32'd1;
    end
  end

  assign stat_redirects = r_stat_redirects;
  assign stat_killed    = r_stat_killed;
`endif

  assign imem_req_valid = rst_n & (r_state == ST_REQ);
  assign imem_addr      = r_pc;
  assign if_id_valid    = r_ifid_valid;
  assign if_id_pc       = r_ifid_pc;
  assign if_id_instr    = r_ifid_instr;
  assign redirect       = w_redirect;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : tb_if_fetch_ctrl
// Brief   : Directed and random stimulus for if_fetch_ctrl against a
//           transaction-level fetch model.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, branch = 1'b0, jump = 1'b0, id_stall = 1'b0;
  logic [31:0] target_pc = 32'h0;
  logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_req_valid, if_id_valid, redirect;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_redirects, stat_killed;
`endif

  if_fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(STEP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .branch         (branch),
    .jump           (jump),
    .target_pc      (target_pc),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
`ifdef FETCH_STATS_EN
    .stat_redirects (stat_redirects),
    .stat_killed    (stat_killed),
`endif
    .redirect       (redirect)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of outstanding fetches (each entry = its kill mark),
  // one buffered instruction slot, the PC and the IF/ID contents.
  bit          m_q[$];
  bit          m_buf_v;
  logic [31:0] m_buf_pc, m_buf_instr;
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  bit          m_ifv;
  int unsigned m_nredir, m_nkill;

  task automatic model_step();
    bit          redir;
    bit          fresh;
    bit          k;
    logic [31:0] fpc, finstr;
    redir  = id_valid & (branch | jump);
    fresh  = 1'b0;
    fpc    = 32'h0;
    finstr = 32'h0;
    if (m_q.size() != 0) begin
      if (imem_rsp_valid) begin
        k = m_q.pop_front();
        if (k || redir) m_nkill++;
        else if (!id_stall) begin
          fresh = 1'b1; fpc = m_pc; finstr = imem_rsp_data; m_pc = m_pc + STEP;
        end else begin
          m_buf_v = 1'b1; m_buf_pc = m_pc; m_buf_instr = imem_rsp_data;
        end
      end else if (redir) begin
        foreach (m_q[i]) m_q[i] = 1'b1;
      end
    end else if (m_buf_v) begin
      if (redir) begin
        m_buf_v = 1'b0; m_nkill++;
      end else if (!id_stall) begin
        m_buf_v = 1'b0; fresh = 1'b1; fpc = m_buf_pc; finstr = m_buf_instr; m_pc = m_pc + STEP;
      end
    end else if (imem_req_ready) begin
      m_q.push_back(redir);
    end
    if (redir) begin
      m_pc = target_pc; m_ifv = 1'b0; m_nredir++;
    end else if (fresh) begin
      m_ifv = 1'b1; m_ifpc = fpc; m_ifinstr = finstr;
    end else if (!id_stall) begin
      m_ifv = 1'b0;
    end
  endtask

  task automatic run_cycle(input bit iv, input bit br, input bit jp, input logic [31:0] tgt,
                           input bit st, input bit rdy, input bit rv);
    @(negedge clk);
    check_val("req_valid", {31'h0, imem_req_valid}, {31'h0, (m_q.size() == 0) && !m_buf_v});
    check_val("imem_addr", imem_addr, m_pc);
    check_val("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_ifv});
    if (m_ifv) begin
      check_val("if_id_pc", if_id_pc, m_ifpc);
      check_val("if_id_instr", if_id_instr, m_ifinstr);
    end
`ifdef FETCH_STATS_EN
    check_val("stat_redirects", stat_redirects, m_nredir);
    check_val("stat_killed", stat_killed, m_nkill);
`endif
    id_valid       = iv;
    branch         = br;
    jump           = jp;
    target_pc      = tgt;
    id_stall       = st;
    imem_req_ready = rdy;
    imem_rsp_valid = rv && (m_q.size() != 0);
    imem_rsp_data  = $urandom;
    #1;
    check_val("redirect", {31'h0, redirect}, {31'h0, iv & (br | jp)});
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    m_buf_v = 1'b0; m_pc = 32'h0; m_ifv = 1'b0; m_ifpc = 32'h0; m_ifinstr = c_NOP_INSTR;
    m_buf_pc = 32'h0; m_buf_instr = 32'h0; m_nredir = 0; m_nkill = 0;
    #12;
    check_val("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_if_id_valid", {31'h0, if_id_valid}, 32'h0);
    check_val("rst_if_id_pc", if_id_pc, 32'h0);
    check_val("rst_if_id_instr", if_id_instr, c_NOP_INSTR);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch 0x0, 0x4, 0x8
    repeat (6) run_cycle(0, 0, 0, 32'h0, 0, 1, 1);
    check_val("seq_if_id_pc", if_id_pc, 32'h8);
    // branch to 0x100 while 0xC is outstanding
    run_cycle(0, 0, 0, 32'h0, 0, 1, 0);
    run_cycle(1, 1, 0, 32'h100, 0, 0, 0);
    run_cycle(0, 0, 0, 32'h0, 0, 0, 1);
    check_val("br_addr", imem_addr, 32'h100);
    check_val("br_flush", {31'h0, if_id_valid}, 32'h0);
    // redirect to the top of the address space, then wrap
    run_cycle(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    run_cycle(0, 0, 0, 32'h0, 0, 1, 0);
    run_cycle(0, 0, 0, 32'h0, 0, 0, 1);
    check_val("wrap_addr", imem_addr, 32'h0);
    check_val("wrap_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
    // stall while the response for 0x0 arrives
    run_cycle(0, 0, 0, 32'h0, 1, 1, 0);
    run_cycle(0, 0, 0, 32'h0, 1, 0, 1);
    run_cycle(0, 0, 0, 32'h0, 1, 0, 0);
    run_cycle(0, 0, 0, 32'h0, 1, 0, 0);
    check_val("stall_hold_pc", if_id_pc, 32'hFFFF_FFFC);
    run_cycle(0, 0, 0, 32'h0, 0, 0, 0);
    check_val("stall_release_pc", if_id_pc, 32'h0);
    // jump while holding a buffered instruction
    run_cycle(0, 0, 0, 32'h0, 0, 1, 0);
    run_cycle(0, 0, 0, 32'h0, 1, 0, 1);
    run_cycle(1, 0, 1, 32'h200, 1, 0, 0);
    check_val("hold_jump_addr", imem_addr, 32'h200);
    check_val("hold_jump_flush", {31'h0, if_id_valid}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = 32'h100;
        default: tgt = $urandom;
      endcase
      run_cycle($urandom_range(1) == 0, $urandom_range(6) == 0, $urandom_range(6) == 0,
                tgt, $urandom_range(9) < 3, $urandom_range(9) < 6, $urandom_range(9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
